btn_event_decoder: RTL and testbench

- Sits directly downstream of the debouncer and consumes its clean_out.
- Classifies the clean level into single-cycle events: press, short press, long press, double click.
- Optional auto-repeat while a long press is held.
- Feeds the interrupt/event aggregator with pulse-wide, registered events.

---
 rtl/btn_evt_pkg.sv | 17 +
 rtl/btn_evt_timer.sv | 38 +++
 rtl/btn_event_decoder.sv | 185 ++++++++++++++++++
 tb/tb_btn_event_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and default tuning constants for the button event decoder.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESS
  } btn_state_e;

  localparam int unsigned BTN_LONG_PRESS_CYCLES = 50;
  localparam int unsigned BTN_DOUBLE_GAP_CYCLES = 20;
  localparam int unsigned BTN_REPEAT_CYCLES     = 10;
  localparam int unsigned BTN_CNT_W             = 16;

endpackage

// File: rtl/btn_evt_timer.sv
// Saturating shared timer with clear / load-1 / increment controls and a
// terminal-count compare against a caller-selected value.
module btn_evt_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  input  logic [CNT_W-1:0] cmp_val,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = CNT_W'(1);
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == cmp_val);

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into press/short/long/double events.
// Define BTN_EVT_REPEAT_EN to enable auto-repeat pulses while a long press is held.
module btn_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_PRESS_CYCLES,
  parameter int unsigned DOUBLE_GAP_CYCLES = BTN_DOUBLE_GAP_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = BTN_REPEAT_CYCLES,
  parameter int unsigned CNT_W             = BTN_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clean_in,
  input  logic enable,
  output logic press_evt,
  output logic short_evt,
  output logic long_evt,
  output logic double_evt,
  output logic repeat_evt,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e       state_d, state_q;
  logic             clean_d, clean_q;
  logic             press_d, press_q;
  logic             short_d, short_q;
  logic             long_d, long_q;
  logic             double_d, double_q;
  logic             rep_d;
  logic             rise;
  logic             tmr_clr, tmr_load1, tmr_inc, tmr_hit;
  logic [CNT_W-1:0] tmr_cmp;

  btn_evt_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .load1   (tmr_load1),
    .inc     (tmr_inc),
    .cmp_val (tmr_cmp),
    .hit     (tmr_hit)
  );

  assign rise    = clean_in & ~clean_q;
  assign clean_d = clean_in;

  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    tmr_load1 = 1'b0;
    tmr_inc   = 1'b0;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;
    rep_d     = 1'b0;

    unique case (state_q)
      PRESSED:     tmr_cmp = LONG_TC;
      WAIT_SECOND: tmr_cmp = GAP_TC;
      default:     tmr_cmp = REP_TC;
    endcase

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = PRESSED;
          tmr_load1 = 1'b1;
          press_d   = 1'b1;
        end
      end
      PRESSED: begin
        if (clean_in && tmr_hit) begin
          state_d = LONG_HELD;
          tmr_clr = 1'b1;
          long_d  = 1'b1;
        end else if (clean_in) begin
          tmr_inc = 1'b1;
        end else begin
          state_d   = WAIT_SECOND;
          tmr_load1 = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!clean_in) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end
`ifdef BTN_EVT_REPEAT_EN
        else if (tmr_hit) begin
          tmr_clr = 1'b1;
          rep_d   = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
`endif
      end
      WAIT_SECOND: begin
        if (clean_in) begin
          state_d  = SECOND_PRESS;
          tmr_clr  = 1'b1;
          double_d = 1'b1;
          press_d  = 1'b1;
        end else if (tmr_hit) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
          short_d = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      SECOND_PRESS: begin
        if (!clean_in) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_clr = 1'b1;
      end
    endcase

    // Disable wins over every transition and drops any pending short press.
    if (!enable) begin
      state_d   = IDLE;
      tmr_clr   = 1'b1;
      tmr_load1 = 1'b0;
      tmr_inc   = 1'b0;
      press_d   = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      double_d  = 1'b0;
      rep_d     = 1'b0;
    end
  end

  // clean_q resets high so a button held through reset is not seen as a rise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      clean_q  <= 1'b1;
      press_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      clean_q  <= clean_d;
      press_q  <= press_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
    end
  end

`ifdef BTN_EVT_REPEAT_EN
  logic rep_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rep_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
    end
  end

  assign repeat_evt = rep_q;
`else
  logic unused_rep;
  assign unused_rep = rep_d;
  assign repeat_evt = 1'b0;
`endif

  assign press_evt  = press_q;
  assign short_evt  = short_q;
  assign long_evt   = long_q;
  assign double_evt = double_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed vector bench for btn_event_decoder (LONG=8, GAP=4, REPEAT=3).
module tb_btn_event_decoder;

  logic clk = 1'b0;
  logic reset_n, clean_in, enable;
  logic press_evt, short_evt, long_evt, double_evt, repeat_evt, busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Expected output vector order: {press, short, long, double, repeat, busy}
  typedef struct {
    logic       rn;
    logic       en;
    logic       cin;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

`ifdef BTN_EVT_REPEAT_EN
  localparam logic [5:0] HR = 6'b000011;
`else
  localparam logic [5:0] HR = 6'b000001;
`endif
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] B  = 6'b000001;
  localparam logic [5:0] P  = 6'b100001;
  localparam logic [5:0] S  = 6'b010000;
  localparam logic [5:0] L  = 6'b001001;
  localparam logic [5:0] D  = 6'b100101;

  btn_event_decoder #(
    .LONG_PRESS_CYCLES (8),
    .DOUBLE_GAP_CYCLES (4),
    .REPEAT_CYCLES     (3),
    .CNT_W             (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clean_in   (clean_in),
    .enable     (enable),
    .press_evt  (press_evt),
    .short_evt  (short_evt),
    .long_evt   (long_evt),
    .double_evt (double_evt),
    .repeat_evt (repeat_evt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rn, input logic en, input logic cin,
                     input logic [5:0] exp, input int unsigned n);
    vec_t v;
    v.rn = rn; v.en = en; v.cin = cin; v.exp = exp;
    for (int unsigned i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step(input logic rn, input logic en, input logic cin);
    reset_n  = rn;
    enable   = en;
    clean_in = cin;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {press_evt, short_evt, long_evt, double_evt, repeat_evt, busy};
  endfunction

  initial begin
    int unsigned long_cnt;
    int unsigned press_cnt;

    reset_n = 1'b0; enable = 1'b1; clean_in = 1'b0;

    // Reset
    add(0, 1, 0, Z, 2);
    add(1, 1, 0, Z, 1);
    // Short press: 3 high, 4 low
    add(1, 1, 1, P, 1);
    add(1, 1, 1, B, 2);
    add(1, 1, 0, B, 3);
    add(1, 1, 0, S, 1);
    add(1, 1, 0, Z, 1);
    // Long press: 12 high then low
    add(1, 1, 1, P, 1);
    add(1, 1, 1, B, 6);
    add(1, 1, 1, L, 1);
    add(1, 1, 1, B, 2);
    add(1, 1, 1, HR, 1);
    add(1, 1, 1, B, 1);
    add(1, 1, 0, Z, 2);
    // Double click: 2 high, 2 low, 2 high, 6 low
    add(1, 1, 1, P, 1);
    add(1, 1, 1, B, 1);
    add(1, 1, 0, B, 2);
    add(1, 1, 1, D, 1);
    add(1, 1, 1, B, 1);
    add(1, 1, 0, Z, 6);
    // Gap boundary: 2 high, 4 low, then immediate high starts a fresh press
    add(1, 1, 1, P, 1);
    add(1, 1, 1, B, 1);
    add(1, 1, 0, B, 3);
    add(1, 1, 0, S, 1);
    add(1, 1, 1, P, 1);
    add(1, 1, 0, B, 3);
    add(1, 1, 0, S, 1);
    add(1, 1, 0, Z, 1);
    // Reset while PRESSED with timer at 5, button held through reset
    add(1, 1, 1, P, 1);
    add(1, 1, 1, B, 4);
    add(0, 1, 1, Z, 1);
    add(1, 1, 1, Z, 3);
    add(1, 1, 0, Z, 1);
    // Enable low during WAIT_SECOND discards the pending short press
    add(1, 1, 1, P, 1);
    add(1, 1, 0, B, 2);
    add(1, 0, 0, Z, 1);
    add(1, 1, 0, Z, 5);
    // Enable rising with button already high gives no press
    add(1, 0, 1, Z, 1);
    add(1, 1, 1, Z, 2);
    add(1, 1, 0, Z, 1);
    // Long hold of 17 samples: repeats at 11, 14, 17 when enabled
    add(1, 1, 1, P, 1);
    add(1, 1, 1, B, 6);
    add(1, 1, 1, L, 1);
    add(1, 1, 1, B, 2);
    add(1, 1, 1, HR, 1);
    add(1, 1, 1, B, 2);
    add(1, 1, 1, HR, 1);
    add(1, 1, 1, B, 2);
    add(1, 1, 1, HR, 1);
    add(1, 1, 0, Z, 2);

    foreach (vecs[i]) begin
      step(vecs[i].rn, vecs[i].en, vecs[i].cin);
      check($sformatf("row%0d", i), outs(), vecs[i].exp);
    end

    // Disable one sample before the long threshold, then keep holding:
    // no long_evt and no new press may follow.
    step(1, 1, 1);
    check("hs_press", outs(), P);
    for (int k = 0; k < 6; k++) step(1, 1, 1);
    check("hs_pre_long", outs(), B);
    step(1, 0, 1);
    check("hs_disabled", outs(), Z);
    long_cnt = 0;
    press_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 1);
      if (long_evt === 1'b1) long_cnt++;
      if (press_evt === 1'b1) press_cnt++;
    end
    check("hs_no_long", 6'(long_cnt), 6'd0);
    check("hs_no_press", 6'(press_cnt), 6'd0);
    step(1, 1, 0);
    check("hs_idle", outs(), Z);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
